// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory (dmemory).
// Port 0 is the core load/store unit and port 1 is the debug/DMA loader. Each accepted
// request takes three cycles: IDLE (handshake), ACCESS (memory cycle), RESP (capture).
// Requests are checked for range and alignment. A rejected request never writes memory.
module dmem_arbiter #(
    parameter logic [31:0] BASE      = 32'h01000000,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_rw,
    input  logic [1:0]  req0_size,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        resp0_valid,
    output logic [31:0] resp0_rdata,
    output logic        resp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_rw,
    input  logic [1:0]  req1_size,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        resp1_valid,
    output logic [31:0] resp1_rdata,
    output logic        resp1_err,

    output logic        mem_read_write,
    output logic [1:0]  mem_access_size,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    // Range checks run in 33 bits so address arithmetic near 2^32 cannot wrap into range.
    localparam logic [32:0] Base33  = {1'b0, BASE};
    localparam logic [32:0] Depth33 = 33'(MEM_DEPTH);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        id_q;
    logic        rw_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        any_valid;
    logic        grant_id;
    logic        handshake;
    logic        sel_rw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [32:0] sel_bytes;
    logic [32:0] sel_end;
    logic        misaligned;
    logic        out_of_range;
    logic        sel_err;
    logic [31:0] rdata_masked;
    logic [31:0] rdata_resp;

    // Round-robin grant: a lone requester wins, on a tie the port not granted last wins.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == StIdle) & any_valid & ~grant_id & ~reset;
        req1_ready = (state_q == StIdle) & any_valid & grant_id & ~reset;
        handshake  = req0_ready | req1_ready;
    end

    // Select the granted request and classify it as good or rejected.
    always_comb begin
        sel_rw    = grant_id ? req1_rw    : req0_rw;
        sel_size  = grant_id ? req1_size  : req0_size;
        sel_addr  = grant_id ? req1_addr  : req0_addr;
        sel_wdata = grant_id ? req1_wdata : req0_wdata;
        case (sel_size)
            2'd0:    sel_bytes = 33'd1;
            2'd1:    sel_bytes = 33'd2;
            default: sel_bytes = 33'd4;
        endcase
        misaligned   = ((sel_size == 2'd1) & sel_addr[0]) |
                       (sel_size[1] & (sel_addr[1:0] != 2'b00));
        // sel_end is meaningless when the address is below BASE, but that case is
        // already rejected by the first term.
        sel_end      = {1'b0, sel_addr} - Base33 + sel_bytes;
        out_of_range = ({1'b0, sel_addr} < Base33) | (sel_end > Depth33);
        sel_err      = misaligned | out_of_range;
    end

    // Zero-extend the registered memory word to the latched access size.
    always_comb begin
        case (size_q)
            2'd0:    rdata_masked = {24'b0, mem_data_out[7:0]};
            2'd1:    rdata_masked = {16'b0, mem_data_out[15:0]};
            default: rdata_masked = mem_data_out;
        endcase
        rdata_resp = (!rw_q && !err_q) ? rdata_masked : 32'b0;
    end

    // Memory drive: latched request always presented, write strobe only during ACCESS.
    assign mem_read_write  = (state_q == StAccess) & rw_q & ~err_q & ~reset;
    assign mem_access_size = size_q;
    assign mem_address     = addr_q;
    assign mem_data_in     = wdata_q;

    // Request FSM with registered single-cycle response outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rw_q         <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'b0;
            wdata_q      <= 32'b0;
            resp0_valid  <= 1'b0;
            resp0_rdata  <= 32'b0;
            resp0_err    <= 1'b0;
            resp1_valid  <= 1'b0;
            resp1_rdata  <= 32'b0;
            resp1_err    <= 1'b0;
        end else begin
            resp0_valid <= 1'b0;
            resp0_rdata <= 32'b0;
            resp0_err   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_rdata <= 32'b0;
            resp1_err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (handshake) begin
                        id_q         <= grant_id;
                        rw_q         <= sel_rw;
                        size_q       <= sel_size;
                        addr_q       <= sel_addr;
                        wdata_q      <= sel_wdata;
                        err_q        <= sel_err;
                        last_grant_q <= grant_id;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    state_q <= StResp;
                end
                StResp: begin
                    if (id_q) begin
                        resp1_valid <= 1'b1;
                        resp1_err   <= err_q;
                        resp1_rdata <= rdata_resp;
                    end else begin
                        resp0_valid <= 1'b1;
                        resp0_err   <= err_q;
                        resp0_rdata <= rdata_resp;
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-addressed memory behind it.
module tb_dmem_arbiter;

    localparam logic [31:0] BASE      = 32'h01000000;
    localparam int          MEM_DEPTH = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_rw;
    logic [1:0]  req0_size;
    logic [31:0] req0_addr, req0_wdata;
    logic        resp0_valid, resp0_err;
    logic [31:0] resp0_rdata;
    logic        req1_valid, req1_ready, req1_rw;
    logic [1:0]  req1_size;
    logic [31:0] req1_addr, req1_wdata;
    logic        resp1_valid, resp1_err;
    logic [31:0] resp1_rdata;
    logic        mem_read_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_address, mem_data_in;
    logic [31:0] mem_data_out;

    logic        mem_clear;
    logic [7:0]  mem [MEM_DEPTH];

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int both_ready_cnt = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.BASE(BASE), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
        .req0_size(req0_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
        .req1_size(req1_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .mem_read_write(mem_read_write), .mem_access_size(mem_access_size),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Behavioural dmemory: little-endian, registered read, out-of-range bytes read as 0.
    function automatic bit in_rng(input logic [31:0] a, input int i);
        return (a >= BASE) && (((a - BASE) + 32'(i)) < 32'(MEM_DEPTH));
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (in_rng(a, i)) w[8*i +: 8] = mem[int'(a - BASE) + i];
        return w;
    endfunction

    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
        end else if (mem_read_write) begin
            for (int i = 0; i < 4; i++)
                if (i < nbytes(mem_access_size) && in_rng(mem_address, i))
                    mem[int'(mem_address - BASE) + i] <= mem_data_in[8*i +: 8];
        end
        mem_data_out <= rd_word(mem_address);
    end

    // Mid-cycle monitors: write strobes seen and cycles with both ports ready.
    always @(negedge clock) begin
        #2;
        if (mem_read_write === 1'b1) wr_count++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) both_ready_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit port, input logic v, input logic rw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            req1_valid = v; req1_rw = rw; req1_size = size; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = v; req0_rw = rw; req0_size = size; req0_addr = addr; req0_wdata = wdata;
        end
    endtask

    // One complete transaction; lat counts falling edges after the handshake edge.
    task automatic run_req(input bit port, input logic rw, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output bit hs, output int lat, output logic [31:0] rdata,
                           output logic err, output bit pulse_ok, output bit other_seen,
                           output int wr_delta);
        int w0;
        bit got;
        hs = 0; got = 0; lat = 0; rdata = '0; err = 1'b0; pulse_ok = 0; other_seen = 0;
        @(negedge clock);
        w0 = wr_count;
        drive(port, 1'b1, rw, size, addr, wdata);
        for (int i = 0; i < 10 && !hs; i++) begin
            #1;
            if (port ? req1_ready : req0_ready) hs = 1;
            @(negedge clock);
        end
        drive(port, 1'b0, rw, size, addr, wdata);
        if (hs) begin
            lat = 1;
            while (!got && lat <= 6) begin
                #1;
                if (port ? resp0_valid : resp1_valid) other_seen = 1;
                if (port ? resp1_valid : resp0_valid) begin
                    got   = 1;
                    rdata = port ? resp1_rdata : resp0_rdata;
                    err   = port ? resp1_err : resp0_err;
                end else begin
                    @(negedge clock);
                    lat++;
                end
            end
            if (got) begin
                @(negedge clock);
                #1;
                pulse_ok = !(port ? resp1_valid : resp0_valid);
            end
        end
        wr_delta = wr_count - w0;
    endtask

    typedef struct packed {
        logic        port;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic port, input logic rw, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.port = port; v.rw = rw; v.size = size; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    vec_t vecs [21];

    initial begin
        bit          hs, pulse_ok, other_seen, seen;
        int          lat, wr_delta, w0, ng;
        logic [31:0] rdata;
        logic        err;
        logic        g [4];

        //            port rw   size  addr          wdata          exp_rdata      err
        vecs[0]  = mk(1'b0, 1'b1, 2'd2, BASE + 4,     32'hDEADBEEF, 32'h00000000, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 2'd2, BASE + 4,     32'h0,        32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 2'd2, BASE,         32'h11223344, 32'h00000000, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 2'd0, BASE + 2,     32'hFFFFFFA5, 32'h00000000, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 2'd2, BASE,         32'h0,        32'h11A53344, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 2'd1, BASE + 2,     32'h0,        32'h000011A5, 1'b0);
        vecs[6]  = mk(1'b0, 1'b0, 2'd0, BASE + 3,     32'h0,        32'h00000011, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 2'd3, BASE + 4,     32'h0,        32'hDEADBEEF, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 2'd1, BASE + 1,     32'h0,        32'h00000000, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 2'd2, BASE + 2,     32'h0,        32'h00000000, 1'b1);
        vecs[10] = mk(1'b1, 1'b1, 2'd2, BASE + 30,    32'hCAFEF00D, 32'h00000000, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 2'd0, 32'h00FFFFFF, 32'h000000EE, 32'h00000000, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 2'd2, BASE + 28,    32'h01020304, 32'h00000000, 1'b0);
        vecs[13] = mk(1'b0, 1'b0, 2'd2, BASE + 28,    32'h0,        32'h01020304, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 2'd2, BASE + 32,    32'hAABBCCDD, 32'h00000000, 1'b1);
        vecs[15] = mk(1'b0, 1'b0, 2'd2, BASE + 28,    32'h0,        32'h01020304, 1'b0);
        vecs[16] = mk(1'b1, 1'b0, 2'd1, BASE + 30,    32'h0,        32'h00000102, 1'b0);
        vecs[17] = mk(1'b0, 1'b0, 2'd1, BASE + 31,    32'h0,        32'h00000000, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 2'd0, BASE + 31,    32'h0,        32'h00000001, 1'b0);
        vecs[19] = mk(1'b1, 1'b1, 2'd1, BASE + 28,    32'hFFFFBEEF, 32'h00000000, 1'b0);
        vecs[20] = mk(1'b0, 1'b0, 2'd2, BASE + 28,    32'h0,        32'h0102BEEF, 1'b0);

        reset = 1'b1;
        mem_clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        repeat (3) @(negedge clock);

        // Ready is masked while reset is high even with a request present.
        req0_valid = 1'b1;
        #1;
        check("ready0_in_reset", 0, 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mem_clear = 1'b0;
        @(negedge clock);
        #1;
        check("rst_resp0_valid", 0, 32'(resp0_valid), 32'd0);
        check("rst_resp1_valid", 0, 32'(resp1_valid), 32'd0);
        check("rst_resp0_rdata", 0, resp0_rdata, 32'd0);
        check("rst_mem_rw", 0, 32'(mem_read_write), 32'd0);
        check("rst_mem_addr", 0, mem_address, 32'd0);
        check("rst_ready1", 0, 32'(req1_ready), 32'd0);

        // Both ports held valid from reset: grants alternate starting with port 0.
        @(negedge clock);
        drive(1'b0, 1'b1, 1'b0, 2'd2, BASE, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd2, BASE + 8, 32'h0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (req0_ready) begin
                g[ng] = 1'b0;
                ng++;
            end else if (req1_ready) begin
                g[ng] = 1'b1;
                ng++;
            end
            @(negedge clock);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("rr_grant_count", 0, ng, 4);
        for (int k = 0; k < ng; k++) check("rr_grant", k, 32'(g[k]), 32'(k % 2));

        // Table of single transactions.
        for (int i = 0; i < 21; i++) begin
            run_req(vecs[i].port, vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    hs, lat, rdata, err, pulse_ok, other_seen, wr_delta);
            check("handshake", i, 32'(hs), 32'd1);
            check("latency", i, lat, 3);
            check("rdata", i, rdata, vecs[i].exp_rdata);
            check("err", i, 32'(err), 32'(vecs[i].exp_err));
            check("pulse_single", i, 32'(pulse_ok), 32'd1);
            check("other_port_quiet", i, 32'(other_seen), 32'd0);
            check("writes", i, wr_delta, (vecs[i].rw && !vecs[i].exp_err) ? 1 : 0);
        end

        // Reset during ACCESS of a write: no write, no response, port 0 wins first tie.
        @(negedge clock);
        w0 = wr_count;
        drive(1'b0, 1'b1, 1'b1, 2'd2, BASE, 32'hFFFFFFFF);
        #1;
        check("rst_mid_ready0", 0, 32'(req0_ready), 32'd1);
        @(negedge clock);
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (5) begin
            #1;
            if (resp0_valid || resp1_valid) seen = 1;
            @(negedge clock);
        end
        check("rst_mid_no_resp", 0, 32'(seen), 32'd0);
        check("rst_mid_no_write", 0, wr_count - w0, 0);
        drive(1'b0, 1'b1, 1'b0, 2'd2, BASE, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd2, BASE + 8, 32'h0);
        #1;
        check("post_rst_ready0", 0, 32'(req0_ready), 32'd1);
        check("post_rst_ready1", 0, 32'(req1_ready), 32'd0);
        @(negedge clock);
        req0_valid = 1'b0;
        hs = 0;
        for (int c = 0; c < 10 && !hs; c++) begin
            #1;
            if (req1_ready) hs = 1;
            @(negedge clock);
        end
        req1_valid = 1'b0;
        check("post_rst_port1_served", 0, 32'(hs), 32'd1);
        repeat (4) @(negedge clock);
        run_req(1'b0, 1'b0, 2'd2, BASE, 32'h0, hs, lat, rdata, err, pulse_ok, other_seen,
                wr_delta);
        check("rst_mid_readback", 0, rdata, 32'h11A53344);
        check("rst_mid_readback_err", 0, 32'(err), 32'd0);

        check("never_both_ready", 0, both_ready_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
